// File: rtl/mult_ctrl.sv
// EX-stage sequential multiplier: owns HI/LO, runs MULT/MULTU as a
// WIDTH-cycle shift-add on one adder, serves MFHI/MFLO/MTHI/MTLO.
module mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic               done_q;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] prod;
    logic               last;

    // Negating the most-negative value yields 2^(W-1) as an unsigned magnitude.
    assign abs_a  = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b  = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    assign addend = {{WIDTH{1'b0}}, mag_a} << count;
    assign sum    = acc + addend;
    assign prod   = neg ? (~acc + 1'b1) : acc;
    assign last   = (count == CW'(WIDTH - 1));

    assign busy   = (state != IDLE);
    assign stall  = busy & (start | mfhi | mflo | mthi | mtlo);
    assign rdata  = mfhi ? hi : lo;
    assign done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            hi     <= '0;
            lo     <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            count  <= '0;
            acc    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                        if (start) begin
                            mag_a <= abs_a;
                            mag_b <= abs_b;
                            neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            acc   <= '0;
                            count <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        if (mag_b[count]) acc <= sum;
                        if (last) begin
                            count <= '0;
                            state <= FIX;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        {hi, lo} <= prod;
                        done_q   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: directed corner cases plus random operands
// checked against a 64-bit arithmetic reference of HI/LO.
module tb_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mfhi;
    logic        mflo;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        stall;
    logic        done;

    int          cmp;
    int          bad;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    mult_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .flush(flush), .mfhi(mfhi), .mflo(mflo),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rdata(rdata),
        .busy(busy), .stall(stall), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic s);
        longint sx;
        longint sy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Called at a negedge while idle; reads HI then LO combinationally.
    task automatic read_hilo(input string tag);
        mfhi = 1'b1;
        #1 check({tag, " hi"}, {32'd0, rdata}, {32'd0, hi_m});
        mfhi = 1'b0;
        mflo = 1'b1;
        #1 check({tag, " lo"}, {32'd0, rdata}, {32'd0, lo_m});
        mflo = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] x,
                          input logic [31:0] y, input logic s);
        int n;
        @(negedge clk);
        a = x;
        b = y;
        signed_op = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        {hi_m, lo_m} = ref_prod(x, y, s);
        check({tag, " busy cycles"}, 64'(n), 64'd33);
        check({tag, " done"}, {63'd0, done}, 64'd1);
        read_hilo(tag);
        @(negedge clk);
        check({tag, " done once"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        cmp = 0;
        bad = 0;
        hi_m = '0;
        lo_m = '0;
        rst_n = 1'b0;
        start = 1'b0;
        signed_op = 1'b0;
        a = '0;
        b = '0;
        flush = 1'b0;
        mfhi = 1'b0;
        mflo = 1'b0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        read_hilo("reset");

        run_op("multu 7*6", 32'd7, 32'd6, 1'b0);
        run_op("mult -3*5", 32'hFFFFFFFD, 32'd5, 1'b1);
        run_op("multu max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("mult -1*-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        run_op("mult min*min", 32'h80000000, 32'h80000000, 1'b1);
        run_op("mult min*1", 32'h80000000, 32'd1, 1'b1);
        check("min*1 model hi", {32'd0, hi_m}, 64'hFFFFFFFF);

        for (int i = 0; i < 10; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = (i == 3) ? 32'd0 : $urandom;
            run_op($sformatf("rand %0d", i), x, y, 1'($urandom_range(0, 1)));
        end

        // MT writes while idle, and both read strobes -> HI
        @(negedge clk);
        mthi = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b1;
        wdata = 32'h9ABC_DEF0;
        hi_m = 32'h1234_5678;
        @(negedge clk);
        mtlo = 1'b0;
        lo_m = 32'h9ABC_DEF0;
        read_hilo("mt idle");
        mfhi = 1'b1;
        mflo = 1'b1;
        #1 check("both strobes", {32'd0, rdata}, {32'd0, hi_m});
        mfhi = 1'b0;
        mflo = 1'b0;

        // MFLO/MTHI during an op: stalled, no write, then new LO
        @(negedge clk);
        a = 32'd1000;
        b = 32'd77;
        signed_op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        mflo = 1'b1;
        mthi = 1'b1;
        wdata = 32'hDEAD_BEEF;
        #1 check("stall mflo", {63'd0, stall}, 64'd1);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        {hi_m, lo_m} = ref_prod(32'd1000, 32'd77, 1'b0);
        check("stall drops", {63'd0, stall}, 64'd0);
        check("lo after stall", {32'd0, rdata}, {32'd0, lo_m});
        mthi = 1'b0;
        mflo = 1'b0;
        read_hilo("mthi busy");

        // start with MT in the same idle cycle: result overwrites
        @(negedge clk);
        a = 32'd3;
        b = 32'd9;
        signed_op = 1'b1;
        start = 1'b1;
        mtlo = 1'b1;
        wdata = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        mtlo = 1'b0;
        check("mt+start busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        {hi_m, lo_m} = ref_prod(32'd3, 32'd9, 1'b1);
        read_hilo("mt+start");

        // flush in idle suppresses start and MT
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        mthi = 1'b1;
        wdata = 32'hAAAA_0000;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        mthi = 1'b0;
        check("idle flush busy", {63'd0, busy}, 64'd0);
        read_hilo("idle flush");

        // flush at RUN cycle 10: aborted, no done, HI/LO kept
        @(negedge clk);
        a = 32'hFFFF_0001;
        b = 32'h0F0F_0F0F;
        signed_op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {63'd0, busy}, 64'd0);
        repeat (3) begin
            check("flush no done", {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        read_hilo("flush keep");

        // async reset mid-op
        a = 32'd12345;
        b = 32'd678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst busy", {63'd0, busy}, 64'd0);
        hi_m = '0;
        lo_m = '0;
        read_hilo("rst mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post reset", 32'hFFFF_FFF9, 32'h0000_0101, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
